// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Single-byte load/store sequencer between the control unit
//                and the 8-bit data memory. Accepts one command at a time,
//                presents address/data, raises the read or write strobe until
//                the memory acknowledges, then returns a one-cycle response
//                and (for loads) a one-cycle DMDR capture pulse.
//
//  Optional feature (compile-time macro):
//    DMEM_TIMEOUT_EN  - bounds the ACCESS phase to TIMEOUT cycles. On expiry
//                       the transaction completes with rsp_err=1 and
//                       rsp_rdata=0, and no DMDR capture. Undefined: ACCESS
//                       waits for mem_ack indefinitely and rsp_err is tied 0.
//
//  Parameters:
//    ADDR_W   memory byte-address width
//    DATA_W   memory data width
//    TIMEOUT  max ACCESS cycles without mem_ack (timeout build only)
//
//  Ports:
//    clk, RST                    clock, synchronous active-high reset
//    cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//    cmd_write/cmd_addr/wdata    command: 1=store, byte address, store data
//    rsp_valid/rsp_rdata/rsp_err one-cycle completion pulse with load data
//                                (0 for stores) and timeout flag
//    dmdr_load                   one-cycle DMDR capture pulse (loads only)
//    mem_addr/mem_wdata          address and write data to data memory
//    mem_rd/mem_wr               read / write strobes (ACCESS only)
//    mem_rdata/mem_ack           read data and acknowledge from memory
//
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              RST,

    // Command interface from the control unit
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    // Response interface back to the control unit / DMDR
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dmdr_load,

    // Data memory interface
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Latched command
    logic                r_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    // Response data holds until the next completion
    logic [DATA_W-1:0]   r_rsp_rdata;

    // Event strobes from the next-state logic
    logic                w_accept;
    logic                w_ack_done;

`ifdef DMEM_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // ACCESS wait counter. It counts ACCESS cycles that end without mem_ack;
    // the transaction is abandoned on the edge that would make the count
    // reach TIMEOUT, so the strobe is high for exactly TIMEOUT cycles.
    // ------------------------------------------------------------------------
    localparam int                c_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic                r_rsp_err;
    logic                w_cnt_last;
    logic                w_timeout_hit;

    assign w_cnt_last = (r_wait_cnt == c_CNT_LAST);
    assign rsp_err    = r_rsp_err;
`else
    // Timeout disabled: the error flag can never be raised. TIMEOUT is
    // folded into a dangling signal so the parameter still has a reader.
    logic                w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT == 0);
    assign rsp_err      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Moore/Mealy control outputs. Strobes and pulses are
    // decoded from the state so a reset drops them in the very next cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ack_done   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        cmd_ready    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        rsp_valid    = 1'b0;
        dmdr_load    = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SETUP;
                end
            end

            // One cycle of address/data setup before the strobe rises.
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end

            S_ACCESS: begin
                mem_rd = ~r_write;
                mem_wr =  r_write;
                // An acknowledge on the final allowed cycle still wins.
                if (mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = S_DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (w_cnt_last) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_DONE;
                end
`endif
            end

            S_DONE: begin
                rsp_valid    = 1'b1;
                // A timed-out load has no valid byte for DMDR to capture.
                dmdr_load    = ~r_write & ~rsp_err;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command latch and response data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            r_write     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write     <= cmd_write;
                r_mem_addr  <= cmd_addr;
                r_mem_wdata <= cmd_wdata;
            end
            if (w_ack_done) begin
                r_rsp_rdata <= r_write ? '0 : mem_rdata;
            end
`ifdef DMEM_TIMEOUT_EN
            if (w_timeout_hit) begin
                r_rsp_rdata <= '0;
            end
`endif
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Wait counter and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            // SETUP always precedes ACCESS, so clearing here gives a fresh
            // count on every entry to ACCESS.
            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !mem_ack && !w_cnt_last) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_accept) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout_hit) begin
                r_rsp_err <= 1'b1;
            end
        end
    end
`endif

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_ctrl
//  Description : Directed self-checking bench for dmem_access_ctrl. Inputs
//                are driven and outputs sampled 1 ns after each rising edge.
//                Timeout scenario is built when DMEM_TIMEOUT_EN is defined,
//                otherwise an unbounded-wait scenario is exercised instead.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int c_ADDR_W  = 18;
    localparam int c_DATA_W  = 8;
    localparam int c_TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                RST;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [c_ADDR_W-1:0] cmd_addr;
    logic [c_DATA_W-1:0] cmd_wdata;
    logic                rsp_valid;
    logic [c_DATA_W-1:0] rsp_rdata;
    logic                rsp_err;
    logic                dmdr_load;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata;
    logic                mem_rd;
    logic                mem_wr;
    logic [c_DATA_W-1:0] mem_rdata;
    logic                mem_ack;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int rd_hi  = 0;
    int wr_hi  = 0;

    dmem_access_ctrl #(
        .ADDR_W  (c_ADDR_W),
        .DATA_W  (c_DATA_W),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dmdr_load (dmdr_load),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock, then tally strobe activity for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_rd) rd_hi++;
        if (mem_wr) wr_hi++;
    endtask

    initial begin
        int t_prev;
        int budget;

        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_rd",    32'(mem_rd),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_dmdr_load", 32'(dmdr_load), 32'd0);
        RST = 1'b0;
        tick();

        // ---------------- 1: single load, immediate ack ----------------
        rd_hi = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00123;
        tick();                                   // accept -> SETUP
        cmd_valid = 1'b0;
        check("t1_setup_ready", 32'(cmd_ready), 32'd0);
        check("t1_setup_rd",    32'(mem_rd),    32'd0);
        check("t1_setup_addr",  32'(mem_addr),  32'h00123);
        tick();                                   // -> ACCESS
        check("t1_access_rd",   32'(mem_rd),    32'd1);
        check("t1_access_wr",   32'(mem_wr),    32'd0);
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        tick();                                   // -> DONE
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("t1_done_valid",  32'(rsp_valid), 32'd1);
        check("t1_done_rdata",  32'(rsp_rdata), 32'hA5);
        check("t1_done_dmdr",   32'(dmdr_load), 32'd1);
        check("t1_done_err",    32'(rsp_err),   32'd0);
        check("t1_done_rd",     32'(mem_rd),    32'd0);
        tick();                                   // -> IDLE
        check("t1_idle_valid",  32'(rsp_valid), 32'd0);
        check("t1_idle_dmdr",   32'(dmdr_load), 32'd0);
        check("t1_idle_ready",  32'(cmd_ready), 32'd1);
        check("t1_hold_rdata",  32'(rsp_rdata), 32'hA5);
        check("t1_hold_addr",   32'(mem_addr),  32'h00123);
        check("t1_rd_cycles",   32'(rd_hi),     32'd1);

        // ---------------- 2: store, ack after 3 waits ----------------
        wr_hi = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h3FFFF; cmd_wdata = 8'h5A;
        tick();                                   // accept
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        tick();                                   // ACCESS, cycle 1
        check("t2_access_wr",   32'(mem_wr),    32'd1);
        check("t2_access_rd",   32'(mem_rd),    32'd0);
        for (int i = 0; i < 3; i++) tick();       // 3 wait cycles
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();                                   // -> DONE
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("t2_wr_cycles",   32'(wr_hi),     32'd4);
        check("t2_done_valid",  32'(rsp_valid), 32'd1);
        check("t2_done_rdata",  32'(rsp_rdata), 32'h00);
        check("t2_done_dmdr",   32'(dmdr_load), 32'd0);
        check("t2_addr",        32'(mem_addr),  32'h3FFFF);
        check("t2_wdata",       32'(mem_wdata), 32'h5A);
        check("t2_done_wr",     32'(mem_wr),    32'd0);
        tick();                                   // -> IDLE

        // ---------------- 3: back-to-back loads, cmd_valid held ----------------
        t_prev = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h10;
        for (int i = 0; i < 3; i++) begin
            tick();                               // accept
            check("t3_setup_ready", 32'(cmd_ready), 32'd0);
            check("t3_setup_addr",  32'(mem_addr),  32'h10 + 32'(i));
            tick();                               // ACCESS
            check("t3_access_ready", 32'(cmd_ready), 32'd0);
            mem_ack = 1'b1; mem_rdata = 8'hC0 + 8'(i);
            tick();                               // DONE
            mem_ack = 1'b0;
            check("t3_done_valid",  32'(rsp_valid), 32'd1);
            check("t3_done_rdata",  32'(rsp_rdata), 32'hC0 + 32'(i));
            check("t3_done_ready",  32'(cmd_ready), 32'd0);
            if (i > 0) check("t3_period", 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
            if (i == 2) cmd_valid = 1'b0;
            else        cmd_addr  = 18'h10 + 18'(i + 1);
            tick();                               // IDLE
            check("t3_idle_ready",  32'(cmd_ready), 32'd1);
            check("t3_idle_valid",  32'(rsp_valid), 32'd0);
        end

        // ---------------- 6: stray mem_ack in IDLE / SETUP ----------------
        mem_ack = 1'b1; mem_rdata = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_ready", 32'(cmd_ready), 32'd1);
            check("t6_idle_valid", 32'(rsp_valid), 32'd0);
        end
        check("t6_idle_rdata", 32'(rsp_rdata), 32'hC2);
        mem_ack = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 18'h00200;
        tick();                                   // accept -> SETUP
        cmd_valid = 1'b0;
        mem_ack = 1'b1;                           // ack sampled in SETUP
        tick();
        check("t6_setup_skip_rd",    32'(mem_rd),    32'd1);
        check("t6_setup_skip_valid", 32'(rsp_valid), 32'd0);
        mem_rdata = 8'h77;                        // ack still high in ACCESS
        tick();
        mem_ack = 1'b0;
        check("t6_done_valid", 32'(rsp_valid), 32'd1);
        check("t6_done_rdata", 32'(rsp_rdata), 32'h77);
        tick();

`ifdef DMEM_TIMEOUT_EN
        // ---------------- 5: access timeout ----------------
        rd_hi = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00400;
        tick();
        cmd_valid = 1'b0;
        budget = 30;
        while (!rsp_valid && budget > 0) begin
            tick();
            budget--;
        end
        check("t5_done_seen",  32'(rsp_valid), 32'd1);
        check("t5_rd_cycles",  32'(rd_hi),     32'(c_TIMEOUT));
        check("t5_err",        32'(rsp_err),   32'd1);
        check("t5_rdata",      32'(rsp_rdata), 32'h00);
        check("t5_dmdr",       32'(dmdr_load), 32'd0);
        check("t5_rd_low",     32'(mem_rd),    32'd0);
        tick();
        check("t5_err_hold",   32'(rsp_err),   32'd1);
        cmd_valid = 1'b1; cmd_addr = 18'h00401;
        tick();
        cmd_valid = 1'b0;
        check("t5_err_clear",  32'(rsp_err),   32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check("t5_good_valid", 32'(rsp_valid), 32'd1);
        check("t5_good_err",   32'(rsp_err),   32'd0);
        check("t5_good_rdata", 32'(rsp_rdata), 32'h3C);
        check("t5_good_dmdr",  32'(dmdr_load), 32'd1);
        tick();
`else
        // ---------------- 5 (no timeout build): unbounded wait ----------------
        rd_hi = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00400;
        tick();
        cmd_valid = 1'b0;
        budget = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) budget++;
        end
        check("t5_no_early_done", 32'(budget),   32'd0);
        check("t5_rd_cycles",     32'(rd_hi),    32'd20);
        check("t5_still_rd",      32'(mem_rd),   32'd1);
        check("t5_err_tied",      32'(rsp_err),  32'd0);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check("t5_late_valid",    32'(rsp_valid), 32'd1);
        check("t5_late_rdata",    32'(rsp_rdata), 32'h3C);
        check("t5_late_err",      32'(rsp_err),   32'd0);
        tick();
`endif

        // ---------------- 4: reset during ACCESS ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00555;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t4_access_rd",  32'(mem_rd),    32'd1);
        RST = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        RST = 1'b0; mem_ack = 1'b0;
        check("t4_rst_rd",     32'(mem_rd),    32'd0);
        check("t4_rst_ready",  32'(cmd_ready), 32'd1);
        check("t4_rst_valid",  32'(rsp_valid), 32'd0);
        check("t4_rst_dmdr",   32'(dmdr_load), 32'd0);
        check("t4_rst_rdata",  32'(rsp_rdata), 32'h00);
        tick();
        check("t4_post_valid", 32'(rsp_valid), 32'd0);
        check("t4_post_rd",    32'(mem_rd),    32'd0);
        check("t4_post_ready", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
